// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: latches a W-bit pattern and shifts it out MSB-first,
// repeating it a programmable number of times with a programmable idle gap between repeats.
module serial_pattern_tx #(
  parameter int unsigned W     = 4,
  parameter int unsigned REP_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [W-1:0]     pattern_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IdxW = $clog2(W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    if (abort_i) begin
      state_d   = StIdle;
      reps_d    = '0;
      gap_cnt_d = '0;
      idx_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_d   = pattern_i;
            reps_d  = reps_i;
            gap_d   = gap_i;
            idx_d   = '0;
            state_d = (reps_i == '0) ? StDone : StSend;
          end
        end
        StSend: begin
          if (idx_q == IdxLast) begin
            idx_d  = '0;
            reps_d = reps_q - REP_W'(1);
            if (reps_q == REP_W'(1)) begin
              state_d = StDone;
            end else if (gap_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = gap_q;
            end
            // Otherwise stay in StSend: back-to-back repeat with no bubble.
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d   = StSend;
            gap_cnt_d = '0;
            idx_d     = '0;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    dout_valid_o = (state_q == StSend);
    dout_o       = dout_valid_o & pat_q[IdxLast - idx_q];
    busy_o       = (state_q == StSend) || (state_q == StGap);
    done_o       = (state_q == StDone);
  end

endmodule
